// File: rtl/ov7670_capture332_if.sv
// ov7670_capture332_if: frame-buffer write port between the capture stage and the frame buffer
// Ports: wr_addr pixel address, wr_data RGB332 pixel, wr_en one-cycle write strobe.
//   master = capture stage (drives), slave = frame buffer (receives).
interface ov7670_capture332_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    modport master(output wr_addr, wr_data, wr_en);
    modport slave(input wr_addr, wr_data, wr_en);
endinterface

// File: rtl/ov7670_capture332.sv
// ov7670_capture332: OV7670 RGB444 byte capture, RGB332 packing and sequential frame-buffer writer
// Ports: pclk camera pixel clock; rst_n async active-low reset; enable capture permission sampled at
//   frame start; cam_vsync/cam_href/cam_d camera bus; fb frame-buffer write port (master);
//   frame_done end-of-frame pulse; pixel_count pixels written in last frame; overflow sticky.
module ov7670_capture332 #(
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_W       = 17
) (
    input  logic                       pclk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       cam_vsync,
    input  logic                       cam_href,
    input  logic [7:0]                 cam_d,
    ov7670_capture332_if.master        fb,
    output logic                       frame_done,
    output logic [ADDR_W-1:0]          pixel_count,
    output logic                       overflow
);
    typedef enum logic {IDLE, CAPTURE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS);
    state_t            state_q, state_d;
    logic              vs_q, hr_q, vs_p_q;
    logic [7:0]        d_q;
    logic              phase_q, phase_d;
    logic [2:0]        r_q, r_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d, pixel_count_q, pixel_count_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d, frame_done_q, frame_done_d, overflow_q, overflow_d;
    logic              start, active, vs_rise, ph, pix, full;
    logic [ADDR_W-1:0] base;
    logic              unused_bits;
    assign unused_bits = ^{d_q[4], d_q[0]};
    always_comb begin
        start   = state_q == IDLE && vs_p_q && !vs_q && enable;
        active  = state_q == CAPTURE || start;
        vs_rise = state_q == CAPTURE && vs_q && !vs_p_q;
        // A frame start clears pointer and byte phase in the same cycle it may take the first byte.
        ph      = start ? 1'b0 : phase_q;
        base    = start ? '0 : ptr_q;
        full    = base == LAST;
        pix     = active && hr_q && ph;
        phase_d = active && !vs_rise && hr_q && !ph;
        r_d     = active && hr_q && !ph ? d_q[3:1] : r_q;
        wr_en_d = pix && !full;
        wr_addr_d = wr_en_d ? base : wr_addr_q;
        wr_data_d = wr_en_d ? {r_q, d_q[7:5], d_q[3:2]} : wr_data_q;
        ptr_d   = base + ADDR_W'(wr_en_d);
        overflow_d = overflow_q || (pix && full);
        state_d = vs_rise ? IDLE : active ? CAPTURE : IDLE;
        frame_done_d = vs_rise;
        // A pixel finishing on the vsync edge is already in ptr_d and thus counted.
        pixel_count_d = vs_rise ? ptr_d : pixel_count_q;
    end
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q          <= 1'b0;
            hr_q          <= 1'b0;
            d_q           <= '0;
            vs_p_q        <= 1'b0;
            state_q       <= IDLE;
            phase_q       <= 1'b0;
            r_q           <= '0;
            ptr_q         <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            pixel_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            vs_q          <= cam_vsync;
            hr_q          <= cam_href;
            d_q           <= cam_d;
            vs_p_q        <= vs_q;
            state_q       <= state_d;
            phase_q       <= phase_d;
            r_q           <= r_d;
            ptr_q         <= ptr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_en_q       <= wr_en_d;
            frame_done_q  <= frame_done_d;
            pixel_count_q <= pixel_count_d;
            overflow_q    <= overflow_d;
        end
    end
    assign fb.wr_addr  = wr_addr_q;
    assign fb.wr_data  = wr_data_q;
    assign fb.wr_en    = wr_en_q;
    assign frame_done  = frame_done_q;
    assign pixel_count = pixel_count_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_ov7670_capture332.sv
// tb_ov7670_capture332: table-driven, hand-sequenced and randomized checks of the capture stage
module tb_ov7670_capture332;
    localparam int FP = 96;
    localparam int AW = 17;
    logic pclk = 0, rst_n = 0, enable = 0, cam_vsync = 0, cam_href = 0;
    logic [7:0] cam_d = 0;
    logic frame_done, overflow;
    logic [AW-1:0] pixel_count;
    ov7670_capture332_if #(.ADDR_W(AW)) fb();
    ov7670_capture332 #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_d(cam_d), .fb(fb), .frame_done(frame_done), .pixel_count(pixel_count), .overflow(overflow)
    );
    always #5 pclk = ~pclk;

    typedef struct {
        bit en; bit drop; int nlines; int first_len; int len; logic [7:0] b0; logic [7:0] b1;
        int exp_w; logic [7:0] exp_data; int exp_pc; bit exp_ovf;
    } vec_t;
    vec_t tbl[7];

    int vectors = 0, miscompares = 0;
    logic [AW-1:0] got_addr[$];
    logic [7:0] got_data[$];
    int fd_cnt = 0, back2back = 0;
    logic [AW-1:0] fd_pc = 0;
    logic prev_we = 0;
    logic [7:0] bytes_q[$];
    int lens_q[$];
    logic [7:0] exp_q[$];
    bit m_ovf = 0;
    logic [AW-1:0] m_pc = 0;

    initial forever begin
        @(negedge pclk);
        if (fb.wr_en) begin
            got_addr.push_back(fb.wr_addr);
            got_data.push_back(fb.wr_data);
        end
        if (fb.wr_en && prev_we) back2back++;
        prev_we = fb.wr_en;
        if (frame_done) begin
            fd_cnt++;
            fd_pc = pixel_count;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic logic [7:0] pack(input logic [7:0] a, input logic [7:0] b);
        int r, g, bl;
        r = a % 16; g = b / 16; bl = b % 16;
        return 8'((r / 2) * 32 + (g / 2) * 4 + bl / 4);
    endfunction

    // Reference: pair bytes within each line, drop odd tails, keep the first FP pixels.
    function automatic void model(input bit en);
        int k, total;
        k = 0; total = 0;
        exp_q.delete();
        if (!en) return;
        foreach (lens_q[l]) begin
            for (int i = 0; i + 1 < lens_q[l]; i += 2) begin
                if (exp_q.size() < FP) exp_q.push_back(pack(bytes_q[k + i], bytes_q[k + i + 1]));
                total++;
            end
            k += lens_q[l];
        end
        if (total > FP) m_ovf = 1;
        m_pc = AW'(exp_q.size());
    endfunction

    task automatic clear_mon();
        got_addr.delete();
        got_data.delete();
        fd_cnt = 0;
    endtask

    task automatic drive_frame(input bit en, input bit drop);
        int k;
        k = 0;
        @(negedge pclk);
        cam_vsync = 1; enable = en; cam_href = 0;
        repeat (3) @(negedge pclk);
        cam_vsync = 0;
        repeat ($urandom_range(3, 1)) @(negedge pclk);
        foreach (lens_q[l]) begin
            for (int i = 0; i < lens_q[l]; i++) begin
                cam_href = 1; cam_d = bytes_q[k]; k++;
                @(negedge pclk);
            end
            cam_href = 0; cam_d = 8'($urandom);
            if (drop) enable = 0;
            repeat (2) @(negedge pclk);
        end
        cam_vsync = 1;
        repeat (6) @(negedge pclk);
        enable = 1;
    endtask

    task automatic check_model(input string tag, input bit en);
        model(en);
        check({tag, " writes"}, got_addr.size(), exp_q.size());
        foreach (got_addr[i]) if (i < exp_q.size()) begin
            check({tag, " addr"}, got_addr[i], i);
            check({tag, " data"}, got_data[i], exp_q[i]);
        end
        check({tag, " frame_done"}, fd_cnt, en);
        check({tag, " pixel_count"}, pixel_count, m_pc);
        check({tag, " overflow"}, overflow, m_ovf);
    endtask

    initial begin
        tbl[0] = '{1, 0, 6, 32, 32, 8'h0F, 8'h0F, 96, 8'hE3, 96, 0};
        tbl[1] = '{1, 0, 1, 32, 32, 8'h0A, 8'h5C, 16, 8'hAB, 16, 0};
        tbl[2] = '{1, 0, 3, 33, 32, 8'h0A, 8'h5C, 48, 8'hAB, 48, 0};
        tbl[3] = '{0, 0, 2, 32, 32, 8'h0F, 8'h0F, 0, 8'h00, 48, 0};
        tbl[4] = '{1, 1, 3, 32, 32, 8'h5A, 8'hC3, 48, 8'hB8, 48, 0};
        tbl[5] = '{1, 0, 7, 32, 32, 8'h0F, 8'h0F, 96, 8'hE3, 96, 1};
        tbl[6] = '{1, 0, 1, 32, 32, 8'h0A, 8'h5C, 16, 8'hAB, 16, 1};

        #12;
        check("reset wr_addr", fb.wr_addr, 0);
        check("reset wr_data", fb.wr_data, 0);
        check("reset wr_en", fb.wr_en, 0);
        check("reset frame_done", frame_done, 0);
        check("reset pixel_count", pixel_count, 0);
        check("reset overflow", overflow, 0);
        @(negedge pclk);
        rst_n = 1;
        repeat (2) @(negedge pclk);

        foreach (tbl[t]) begin
            bytes_q.delete(); lens_q.delete();
            for (int l = 0; l < tbl[t].nlines; l++) begin
                int n;
                n = l == 0 ? tbl[t].first_len : tbl[t].len;
                lens_q.push_back(n);
                for (int i = 0; i < n; i++) bytes_q.push_back(i % 2 ? tbl[t].b1 : tbl[t].b0);
            end
            clear_mon();
            drive_frame(tbl[t].en, tbl[t].drop);
            check($sformatf("tbl%0d writes", t), got_addr.size(), tbl[t].exp_w);
            foreach (got_addr[i]) begin
                check($sformatf("tbl%0d addr", t), got_addr[i], i);
                check($sformatf("tbl%0d data", t), got_data[i], tbl[t].exp_data);
            end
            check($sformatf("tbl%0d frame_done", t), fd_cnt, tbl[t].en);
            if (tbl[t].en) check($sformatf("tbl%0d pc_at_done", t), fd_pc, tbl[t].exp_pc);
            check($sformatf("tbl%0d pixel_count", t), pixel_count, tbl[t].exp_pc);
            check($sformatf("tbl%0d overflow", t), overflow, tbl[t].exp_ovf);
        end
        m_ovf = tbl[6].exp_ovf;
        m_pc = AW'(tbl[6].exp_pc);

        // Latency: second byte on cam_d before edge k, write visible after edge k+1 only.
        clear_mon();
        @(negedge pclk); cam_vsync = 1; repeat (3) @(negedge pclk);
        cam_vsync = 0; repeat (2) @(negedge pclk);
        cam_href = 1; cam_d = 8'h0A;
        @(negedge pclk); cam_d = 8'h5C;
        @(posedge pclk); #1;
        check("lat edge k wr_en", fb.wr_en, 0);
        @(negedge pclk); cam_href = 0;
        @(posedge pclk); #1;
        check("lat edge k+1 wr_en", fb.wr_en, 1);
        check("lat wr_addr", fb.wr_addr, 0);
        check("lat wr_data", fb.wr_data, 8'hAB);
        @(posedge pclk); #1;
        check("lat edge k+2 wr_en", fb.wr_en, 0);
        check("lat hold wr_data", fb.wr_data, 8'hAB);
        @(negedge pclk); cam_vsync = 1; repeat (6) @(negedge pclk);
        check("lat frame_done", fd_cnt, 1);
        check("lat pixel_count", pixel_count, 1);
        m_pc = 1;

        for (int f = 0; f < 25; f++) begin
            bit en, drop;
            int nl;
            en = $urandom_range(7, 0) != 0;
            drop = $urandom_range(1, 0) == 1;
            nl = $urandom_range(8, 0);
            bytes_q.delete(); lens_q.delete();
            for (int l = 0; l < nl; l++) begin
                int n;
                n = $urandom_range(40, 0);
                lens_q.push_back(n);
                for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
            end
            clear_mon();
            drive_frame(en, drop);
            check_model($sformatf("rnd%0d", f), en);
        end

        // Reset in the middle of a frame, then a line before any new frame start.
        @(negedge pclk); cam_vsync = 1; enable = 1; repeat (3) @(negedge pclk);
        cam_vsync = 0; @(negedge pclk);
        for (int i = 0; i < 40; i++) begin
            cam_href = 1; cam_d = 8'h0F;
            @(negedge pclk);
        end
        @(posedge pclk); #2;
        rst_n = 0;
        #1;
        check("midrst wr_addr", fb.wr_addr, 0);
        check("midrst wr_data", fb.wr_data, 0);
        check("midrst wr_en", fb.wr_en, 0);
        check("midrst frame_done", frame_done, 0);
        check("midrst pixel_count", pixel_count, 0);
        check("midrst overflow", overflow, 0);
        repeat (2) @(negedge pclk);
        rst_n = 1;
        clear_mon();
        for (int i = 0; i < 32; i++) begin
            cam_href = 1; cam_d = 8'($urandom);
            @(negedge pclk);
        end
        cam_href = 0;
        repeat (4) @(negedge pclk);
        check("postrst no writes", got_addr.size(), 0);
        m_ovf = 0; m_pc = 0;
        bytes_q.delete(); lens_q.delete();
        lens_q.push_back(32);
        for (int i = 0; i < 32; i++) bytes_q.push_back(i % 2 ? 8'h5C : 8'h0A);
        clear_mon();
        drive_frame(1, 0);
        check_model("postrst", 1);

        check("no back-to-back wr_en", back2back, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ov7670_capture332.md
# ov7670_capture332

Camera capture stage feeding the QVGA frame buffer that the VGA display stage reads. Samples the OV7670 8-bit parallel bus in RGB444 mode, assembles two bytes per pixel, packs each pixel to RGB332, and writes it sequentially into the 320 x 240 frame buffer at addresses 0..76799. Runs entirely in the camera pixel-clock domain; the frame buffer's second port provides the domain crossing to the display.

## Interface
- FRAME_PIXELS, 76800: pixels per frame; last valid address is FRAME_PIXELS-1.
- ADDR_W, 17: frame-buffer address width.

- pclk  in  1  camera pixel clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture permission; sampled only at frame start.
- cam_vsync  in  1  camera VSYNC, high during vertical blanking.
- cam_href  in  1  camera HREF, high while line bytes are valid.
- cam_d  in  8  camera data byte.
- wr_addr  out  ADDR_W  frame-buffer write address.
- wr_data  out  8  RGB332 pixel: {R[3:1], G[3:1], B[3:2]}.
- wr_en  out  1  one-cycle write strobe.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- pixel_count  out  ADDR_W  pixels written in the last completed frame.
- overflow  out  1  sticky: a frame delivered more than FRAME_PIXELS pixels.

## Operation
- Input stage: cam_vsync, cam_href and cam_d are registered once (vs_q, hr_q, d_q). All decisions use the registered copies.
- States:
  - IDLE: waits for a vs_q falling edge. If enable = 1 at that edge -> CAPTURE, clear the write pointer and byte phase. Otherwise stay in IDLE and skip the frame.
  - CAPTURE: on each cycle with hr_q = 1, toggle the byte phase.
    - Phase 0 byte: low nibble is R.
    - Phase 1 byte: high nibble G, low nibble B. Completes the pixel.
    - A vs_q rising edge -> IDLE and pulse frame_done.
- Byte phase resets to 0 on every hr_q falling edge. An odd trailing byte in a line is discarded.
- Pixel write:
  - When the pointer < FRAME_PIXELS: register wr_addr = pointer and wr_data = packed pixel, assert wr_en, then increment the pointer.
  - When the pointer = FRAME_PIXELS: no write, the pointer holds, and overflow is set.
  - The pointer never wraps within a frame.
- frame_done: pixel_count latches the pointer value (pixels actually written, 0..FRAME_PIXELS). A short frame is still reported, with its smaller count.
- enable falling mid-frame does not abort the frame; the current frame completes.
- overflow clears only on reset.
- Reset values: wr_addr 0, wr_data 0, wr_en 0, frame_done 0, pixel_count 0, overflow 0, state IDLE, byte phase 0, input registers 0.
- Reset asserted mid-frame: all state clears immediately. Capture resumes only after the next vs_q falling edge.

## Timing
- Latency: the second byte of a pixel, present on cam_d before edge k, is in d_q after edge k. wr_en/wr_addr/wr_data are high and valid during the cycle following edge k+1, for exactly one cycle.
- Maximum write rate: one pixel per 2 pclk cycles. wr_en is never high on two consecutive cycles.
- frame_done: asserts in the cycle after the edge where vs_q is first seen high, for exactly one cycle. pixel_count is valid in the same cycle.
- A pixel completing on the same edge as the vs_q rising edge is written before frame_done. It is counted in pixel_count.
- The frame-start edge and the first hr_q = 1 may be as close as one cycle apart; the first byte is captured.
- wr_addr and wr_data hold their last values when wr_en = 0.

## Test plan
- Full frame, enable = 1: 240 lines x 640 bytes with pixel bytes 0x0F, 0x0F -> 76800 writes, addresses 0..76799, wr_data = 0xE3, frame_done once, pixel_count = 76800, overflow = 0.
- Packing: bytes 0x0A, 0x5C -> wr_data = {101, 010, 11} = 0xAB. Check the 2-cycle latency from the second byte on cam_d to wr_en.
- Odd line: one line of 641 bytes, then normal lines -> the trailing byte is dropped. The next line's first pixel is assembled from its own first two bytes; no address skew.
- Overflow: 241 lines of 640 bytes -> writes stop at address 76799, overflow = 1, pixel_count = 76800. A subsequent normal frame still writes from address 0, and overflow stays 1.
- Enable gating: enable = 0 at frame start -> zero writes and no frame_done for that frame. Enable dropped mid-frame -> that frame completes.
- Reset mid-frame: assert rst_n = 0 at pixel 1000 -> all outputs 0 asynchronously. After release, no writes until the next vsync falling edge; then writes start at address 0.
